// File: rtl/rv_out_trace_pkg.sv
// Shared definitions for the CPU output-bus trace logger: default sizes, entry
// field layout, logging event kinds and elaboration-time helpers.
package rv_out_trace_pkg;

   localparam int OUT_W_DEF  = 10;
   localparam int TS_W_DEF   = 16;
   localparam int DEPTH_DEF  = 8;
   localparam int DROP_W_DEF = 8;

   // Entry layout, LSB first: wrap flag, timestamp, captured output value.
   localparam int WRAP_POS = 0;
   localparam int TS_LSB   = 1;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_WRITE = 2'd1,
      EV_DROP  = 2'd2
   } log_ev_e;

   function automatic int entry_w(input int out_w, input int ts_w);
      return out_w + ts_w + 1;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/rv_trace_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry.
// Pointers rely on DEPTH being a power of two so they wrap naturally.
module rv_trace_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      pop_ok_s  = pop && (count_r != '0);
      push_ok_s = push && ((count_r != (AW+1)'(DEPTH)) || pop_ok_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == '0);

endmodule

// File: rtl/rv_out_trace.sv
// Trace logger for the CPU output bus: timestamps every value change into a
// show-ahead buffer drained by valid/ready, with sticky overflow accounting.
module rv_out_trace
   import rv_out_trace_pkg::*;
#(
   parameter int OUT_W  = OUT_W_DEF,
   parameter int TS_W   = TS_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int DROP_W = DROP_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [OUT_W-1:0]        cpu_out,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [OUT_W-1:0]        rd_data,
   output logic [TS_W-1:0]         rd_ts,
   output logic                    rd_wrap,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [DROP_W-1:0]       drop_cnt,
   input  logic                    clr_ovf
);

   localparam int ENTRY_W  = entry_w(OUT_W, TS_W);
   localparam int DATA_LSB = TS_LSB + TS_W;

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("rv_out_trace: DEPTH must be a power of two and at least 2");
   end

   logic [TS_W-1:0]    ts_r;
   logic               wrap_pend_r;
   logic [OUT_W-1:0]   prev_out_r;
   logic               primed_r;
   logic               overflow_r;
   logic [DROP_W-1:0]  drop_cnt_r;

   logic               log_s;
   logic               pop_s;
   logic               push_s;
   log_ev_e            ev_s;
   logic [ENTRY_W-1:0] din_s;
   logic [ENTRY_W-1:0] dout_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;

   // Change detection and the write/drop decision for this cycle.
   always_comb begin
      log_s = 1'b0;
      ev_s  = EV_NONE;
      if (enable) begin
         log_s = !primed_r || (cpu_out != prev_out_r);
      end else begin
         log_s = 1'b0;
      end
      pop_s = !fifo_empty_s && rd_ready;
      if (!log_s) begin
         ev_s = EV_NONE;
      end else if (!fifo_full_s || pop_s) begin
         ev_s = EV_WRITE;
      end else begin
         ev_s = EV_DROP;
      end
      push_s = (ev_s == EV_WRITE);
      din_s  = {cpu_out, ts_r, wrap_pend_r};
   end

   // Timestamp, wrap tracking, change history and overflow accounting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ts_r        <= '0;
         wrap_pend_r <= 1'b0;
         prev_out_r  <= '0;
         primed_r    <= 1'b0;
         overflow_r  <= 1'b0;
         drop_cnt_r  <= '0;
      end else begin
         ts_r <= ts_r + TS_W'(1);
         if (enable) begin
            prev_out_r <= cpu_out;
            primed_r   <= 1'b1;
         end
         // A rollover in the same cycle as a write must survive for the next entry.
         if (ts_r == {TS_W{1'b1}}) begin
            wrap_pend_r <= 1'b1;
         end else if (push_s) begin
            wrap_pend_r <= 1'b0;
         end
         case (ev_s)
            EV_DROP: begin
               overflow_r <= 1'b1;
               if (clr_ovf) begin
                  drop_cnt_r <= DROP_W'(1);
               end else if (drop_cnt_r != {DROP_W{1'b1}}) begin
                  drop_cnt_r <= drop_cnt_r + DROP_W'(1);
               end
            end
            default: begin
               if (clr_ovf) begin
                  overflow_r <= 1'b0;
                  drop_cnt_r <= '0;
               end
            end
         endcase
      end
   end

   rv_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (din_s),
      .dout  (dout_s),
      .count (count),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign rd_valid = !fifo_empty_s;
   assign rd_data  = dout_s[DATA_LSB +: OUT_W];
   assign rd_ts    = dout_s[TS_LSB +: TS_W];
   assign rd_wrap  = dout_s[WRAP_POS];
   assign overflow = overflow_r;
   assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_rv_out_trace.sv
// Self-checking bench for rv_out_trace: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_rv_out_trace;

   localparam int OUT_W  = 10;
   localparam int TS_W   = 4;
   localparam int DEPTH  = 8;
   localparam int DROP_W = 3;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [OUT_W-1:0]  cpu_out;
   logic              rd_valid;
   logic              rd_ready;
   logic [OUT_W-1:0]  rd_data;
   logic [TS_W-1:0]   rd_ts;
   logic              rd_wrap;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;
   logic              clr_ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv_out_trace #(
      .OUT_W  (OUT_W),
      .TS_W   (TS_W),
      .DEPTH  (DEPTH),
      .DROP_W (DROP_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .cpu_out  (cpu_out),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_ts    (rd_ts),
      .rd_wrap  (rd_wrap),
      .count    (count),
      .overflow (overflow),
      .drop_cnt (drop_cnt),
      .clr_ovf  (clr_ovf)
   );

   // Reference model: the change log is a plain queue of entries.
   typedef struct {
      logic [OUT_W-1:0] d;
      int               ts;
      bit               w;
   } ent_t;

   ent_t             mq[$];
   int               m_ts;
   bit               m_wrap;
   bit               m_primed;
   bit               m_ovf;
   int               m_drop;
   logic [OUT_W-1:0] m_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit   pop, lg, full, wr, drop;
      ent_t e;
      if (!reset) begin
         mq.delete();
         m_ts = 0; m_wrap = 0; m_primed = 0; m_ovf = 0; m_drop = 0; m_prev = '0;
         return;
      end
      pop  = (mq.size() != 0) && rd_ready;
      lg   = enable && (!m_primed || (cpu_out != m_prev));
      full = (mq.size() == DEPTH);
      wr   = lg && (!full || pop);
      drop = lg && full && !pop;
      e.d = cpu_out; e.ts = m_ts; e.w = m_wrap;
      if (enable) begin
         m_prev = cpu_out;
         m_primed = 1;
      end
      if (pop) void'(mq.pop_front());
      if (wr) begin
         mq.push_back(e);
         m_wrap = 0;
      end
      if (m_ts == (2**TS_W) - 1) m_wrap = 1;
      m_ts = (m_ts + 1) % (2**TS_W);
      if (drop) begin
         m_ovf = 1;
         if (clr_ovf) m_drop = 1;
         else if (m_drop < (2**DROP_W) - 1) m_drop = m_drop + 1;
      end else if (clr_ovf) begin
         m_ovf = 0;
         m_drop = 0;
      end
   endtask

   task automatic model_check(input string tag);
      chk({tag, ".valid"}, 32'(rd_valid), 32'(mq.size() != 0));
      chk({tag, ".count"}, 32'(count), 32'(mq.size()));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
      if (mq.size() != 0) begin
         chk({tag, ".data"}, 32'(rd_data), 32'(mq[0].d));
         chk({tag, ".ts"}, 32'(rd_ts), 32'(mq[0].ts));
         chk({tag, ".wrap"}, 32'(rd_wrap), 32'(mq[0].w));
      end
   endtask

   // One clock edge: model follows the inputs the DUT sampled, outputs read 1ns later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic             en;
      logic [OUT_W-1:0] out;
      logic             rdy;
      logic             ev;
      logic [OUT_W-1:0] ed;
      logic [TS_W-1:0]  ets;
      logic             ew;
      int               ec;
   } vec_t;

   vec_t tbl[19];

   initial begin
      logic [OUT_W-1:0] exp_q[$];
      int prob[4];

      tbl[0]  = '{1'b1, 10'h000, 1'b0, 1'b1, 10'h000, 4'd0,  1'b0, 1};
      tbl[1]  = '{1'b1, 10'h000, 1'b0, 1'b1, 10'h000, 4'd0,  1'b0, 1};
      tbl[2]  = '{1'b1, 10'h000, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[3]  = '{1'b1, 10'h000, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[4]  = '{1'b1, 10'h000, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[5]  = '{1'b1, 10'h155, 1'b1, 1'b1, 10'h155, 4'd5,  1'b0, 1};
      tbl[6]  = '{1'b1, 10'h155, 1'b0, 1'b1, 10'h155, 4'd5,  1'b0, 1};
      tbl[7]  = '{1'b1, 10'h155, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[8]  = '{1'b1, 10'h155, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[9]  = '{1'b1, 10'h2AA, 1'b1, 1'b1, 10'h2AA, 4'd9,  1'b0, 1};
      tbl[10] = '{1'b1, 10'h2AA, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[11] = '{1'b0, 10'h3FF, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[12] = '{1'b1, 10'h2AA, 1'b0, 1'b0, 10'h000, 4'd0,  1'b0, 0};
      tbl[13] = '{1'b1, 10'h3FF, 1'b0, 1'b1, 10'h3FF, 4'd13, 1'b0, 1};
      tbl[14] = '{1'b1, 10'h3FF, 1'b0, 1'b1, 10'h3FF, 4'd13, 1'b0, 1};
      tbl[15] = '{1'b1, 10'h001, 1'b0, 1'b1, 10'h3FF, 4'd13, 1'b0, 2};
      tbl[16] = '{1'b1, 10'h001, 1'b1, 1'b1, 10'h001, 4'd15, 1'b0, 1};
      tbl[17] = '{1'b1, 10'h002, 1'b1, 1'b1, 10'h002, 4'd1,  1'b1, 1};
      tbl[18] = '{1'b1, 10'h002, 1'b1, 1'b0, 10'h000, 4'd0,  1'b0, 0};

      // Reset held for three edges, then all outputs must read zero.
      reset = 1'b0; enable = 1'b1; cpu_out = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("rst.valid", 32'(rd_valid), 32'd0);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.overflow", 32'(overflow), 32'd0);
      chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst.data", 32'(rd_data), 32'd0);
      chk("rst.ts", 32'(rd_ts), 32'd0);
      chk("rst.wrap", 32'(rd_wrap), 32'd0);

      // Directed table: first log, ordered changes, enable gating, ts rollover.
      reset = 1'b1;
      for (int i = 0; i < 19; i++) begin
         enable = tbl[i].en; cpu_out = tbl[i].out; rd_ready = tbl[i].rdy;
         tick();
         chk($sformatf("tbl%0d.valid", i), 32'(rd_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].ec));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d.data", i), 32'(rd_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d.ts", i), 32'(rd_ts), 32'(tbl[i].ets));
            chk($sformatf("tbl%0d.wrap", i), 32'(rd_wrap), 32'(tbl[i].ew));
         end
      end

      // Eleven changes into an undrained buffer: eight kept, three dropped.
      enable = 1'b1; rd_ready = 1'b0;
      for (int i = 0; i < 11; i++) begin
         cpu_out = 10'h101 + OUT_W'(i);
         tick();
      end
      chk("fill.count", 32'(count), 32'd8);
      chk("fill.overflow", 32'(overflow), 32'd1);
      chk("fill.drop_cnt", 32'(drop_cnt), 32'd3);
      chk("fill.head", 32'(rd_data), 32'h101);

      // Full buffer, change together with a pop: write succeeds, no drop.
      cpu_out = 10'h200; rd_ready = 1'b1;
      tick();
      chk("fullpop.count", 32'(count), 32'd8);
      chk("fullpop.drop_cnt", 32'(drop_cnt), 32'd3);
      chk("fullpop.head", 32'(rd_data), 32'h102);

      // Drop coinciding with clear: the drop wins and restarts the count at 1.
      cpu_out = 10'h201; rd_ready = 1'b0; clr_ovf = 1'b1;
      tick();
      chk("dropclr.overflow", 32'(overflow), 32'd1);
      chk("dropclr.drop_cnt", 32'(drop_cnt), 32'd1);
      tick();
      chk("clr.overflow", 32'(overflow), 32'd0);
      chk("clr.drop_cnt", 32'(drop_cnt), 32'd0);
      clr_ovf = 1'b0;

      // Drain in order with capture disabled.
      for (int i = 2; i <= 8; i++) exp_q.push_back(10'h100 + OUT_W'(i));
      exp_q.push_back(10'h200);
      enable = 1'b0; rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d.valid", i), 32'(rd_valid), 32'd1);
         chk($sformatf("drain%0d.data", i), 32'(rd_data), 32'(exp_q[i]));
         tick();
      end
      chk("drain.empty", 32'(rd_valid), 32'd0);

      // Mid-operation reset with five entries held.
      enable = 1'b1; rd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cpu_out = 10'h050 + OUT_W'(i);
         tick();
      end
      chk("pre_rst.count", 32'(count), 32'd5);
      reset = 1'b0;
      tick();
      chk("midrst.count", 32'(count), 32'd0);
      chk("midrst.valid", 32'(rd_valid), 32'd0);
      chk("midrst.overflow", 32'(overflow), 32'd0);
      chk("midrst.data", 32'(rd_data), 32'd0);
      reset = 1'b1;
      tick();
      chk("postrst.count", 32'(count), 32'd1);
      chk("postrst.data", 32'(rd_data), 32'h054);
      chk("postrst.ts", 32'(rd_ts), 32'd0);
      chk("postrst.wrap", 32'(rd_wrap), 32'd0);

      // Randomized traffic against the model, with varying drain pressure.
      prob[0] = 0; prob[1] = 20; prob[2] = 50; prob[3] = 90;
      for (int blk = 0; blk < 8; blk++) begin
         for (int c = 0; c < 100; c++) begin
            reset    = ($urandom_range(0, 199) != 0);
            enable   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 9) == 0) cpu_out = OUT_W'($urandom);
               else cpu_out = OUT_W'($urandom_range(0, 3));
            end
            rd_ready = ($urandom_range(0, 99) < prob[blk % 4]);
            clr_ovf  = ($urandom_range(0, 49) == 0);
            tick();
            model_check($sformatf("rnd%0d_%0d", blk, c));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
